ex_stage: RTL

- Execute stage of the tinyMIPS 5-stage pipeline. It sits between the ID/EX pipeline register and the EX/MEM pipeline register.
- It consumes the decoded operation (aluop/alusel), the forwarded operands and the writeback target produced by decode.
- It produces the combinational writeback result. That result also feeds decode's EX forwarding path (ex_wreg/ex_wd/ex_wdata).
- It owns the HI/LO registers and a 32-iteration sequential divider, which stalls the pipeline while it runs.

---
 rtl/ex_stage.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the tinyMIPS 5-stage pipeline.
//
// Computes the combinational writeback result, which feeds both the EX/MEM
// register and decode's EX forwarding path. Owns HI/LO and a sequential
// restoring divider that stalls the pipeline while it runs.
//
// Ports:
//   clk, rst_n           pipeline clock (rising edge), synchronous active-low reset
//   flush_i              abort an in-flight divide, divider back to IDLE
//   aluop_i, alusel_i    decoded operation and result class
//   reg1_i, reg2_i       forwarded operands (reg1_i[4:0] is the shift amount)
//   wd_i, wreg_i         destination register address / write enable
//   wd_o, wreg_o         destination to EX/MEM and forwarding
//   wdata_o              result
//   stallreq_o           stall request while a divide is in progress
//   hi_o, lo_o           HI/LO registers
//
// Build option:
//   EX_OVERFLOW_TRAP_EN  when defined, ADD/SUB suppress the register write on
//                        signed overflow; otherwise they behave as ADDU/SUBU.
//
// Divider states:
//   state    | meaning
//   IDLE     | no divide running; a DIV/DIVU here latches operands
//   DBZ      | divisor was zero; result is fixed, one cycle then END
//   ON       | one shift-subtract iteration per cycle
//   END      | sign fix-up and HI/LO write; pipeline released

module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [7:0] OP_AND  = 8'h24, OP_OR   = 8'h25, OP_XOR  = 8'h26, OP_NOR = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C, OP_SRL  = 8'h02, OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLT  = 8'h2A, OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_ADD  = 8'h20, OP_SUB  = 8'h22;
    localparam logic [7:0] OP_DIV  = 8'h1A, OP_DIVU = 8'h1B, OP_MFHI = 8'h10, OP_MFLO = 8'h12;

    localparam logic [2:0] SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_MOVE = 3'd3, SEL_ARITH = 3'd4;

    localparam logic [4:0] CNT_LAST = 5'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_DBZ,
        DIV_ON,
        DIV_END
    } div_state_e;

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_div;
    logic        is_sdiv;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;
    logic [32:0] trial;
    logic [32:0] trial_sub;
    logic        stall;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        ov_trap;

    assign is_div  = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign is_sdiv = (aluop_i == OP_DIV);
    assign dvd_abs = (is_sdiv && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    assign dvs_abs = (is_sdiv && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

    // quo_q holds the not-yet-consumed dividend bits in its top, quotient bits
    // shift in at the bottom; rem_q < dvs_q always, so the difference fits 32 bits.
    assign trial     = {rem_q, quo_q[31]};
    assign trial_sub = trial - {1'b0, dvs_q};

    assign sum   = reg1_i + reg2_i;
    assign diff  = reg1_i - reg2_i;
    assign shamt = reg1_i[4:0];

`ifdef EX_OVERFLOW_TRAP_EN
    logic add_ov;
    logic sub_ov;
    assign add_ov  = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
    assign sub_ov  = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
    assign ov_trap = (alusel_i == SEL_ARITH) &&
                     (((aluop_i == OP_ADD) && add_ov) || ((aluop_i == OP_SUB) && sub_ov));
`else
    assign ov_trap = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stall     = 1'b0;
        if (flush_i) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (is_div) begin
                        stall = 1'b1;
                        cnt_d = 5'd0;
                        if (reg2_i == 32'd0) begin
                            // Final result is fixed: no sign fix-up applies.
                            state_d   = DIV_DBZ;
                            quo_d     = 32'hFFFF_FFFF;
                            rem_d     = reg1_i;
                            neg_quo_d = 1'b0;
                            neg_rem_d = 1'b0;
                        end else begin
                            state_d   = DIV_ON;
                            quo_d     = dvd_abs;
                            dvs_d     = dvs_abs;
                            rem_d     = 32'd0;
                            neg_quo_d = is_sdiv && (reg1_i[31] ^ reg2_i[31]);
                            neg_rem_d = is_sdiv && reg1_i[31];
                        end
                    end
                end
                DIV_ON: begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 5'd1;
                    if (!trial_sub[32]) begin
                        rem_d = trial_sub[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = trial[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = DIV_END;
                    end
                end
                DIV_DBZ: begin
                    stall   = 1'b1;
                    state_d = DIV_END;
                end
                DIV_END: begin
                    state_d = DIV_IDLE;
                    lo_d    = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
                    hi_d    = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        result = 32'd0;
        case (alusel_i)
            SEL_LOGIC: begin
                case (aluop_i)
                    OP_AND:  result = reg1_i & reg2_i;
                    OP_OR:   result = reg1_i | reg2_i;
                    OP_XOR:  result = reg1_i ^ reg2_i;
                    OP_NOR:  result = ~(reg1_i | reg2_i);
                    default: result = 32'd0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_i)
                    OP_SLL:  result = reg2_i << shamt;
                    OP_SRL:  result = reg2_i >> shamt;
                    OP_SRA:  result = $signed(reg2_i) >>> shamt;
                    default: result = 32'd0;
                endcase
            end
            SEL_MOVE: begin
                case (aluop_i)
                    OP_MFHI: result = hi_q;
                    OP_MFLO: result = lo_q;
                    default: result = 32'd0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_i)
                    OP_ADDU, OP_ADD: result = sum;
                    OP_SUBU, OP_SUB: result = diff;
                    OP_SLT:  result = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
                    OP_SLTU: result = {31'd0, reg1_i < reg2_i};
                    default: result = 32'd0;
                endcase
            end
            default: result = 32'd0;
        endcase

        if (!rst_n) begin
            wd_o       = 5'd0;
            wreg_o     = 1'b0;
            wdata_o    = 32'd0;
            stallreq_o = 1'b0;
        end else begin
            wd_o       = wd_i;
            wreg_o     = wreg_i && !is_div && !ov_trap;
            wdata_o    = is_div ? 32'd0 : result;
            stallreq_o = stall;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
